imm_decode_stage: RTL and testbench

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

---
 rtl/imm_decode_stage.sv | 177 +++++++++++++++++
 tb/tb_imm_decode_stage.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_stage.sv
// Immediate decode stage: decodes the RISC-V immediate, format and branch/jump
// target of each instruction and passes it downstream through a 2-entry skid
// buffer (output register + skid register) with a registered in_ready.
// Also keeps a saturating count of accepted illegal encodings.
module imm_decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [XLEN-1:0]  out_target,
    output logic             out_illegal,
    input  logic             flush,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic [XLEN-1:0] target;
        logic            illegal;
    } entry_t;

    entry_t            dec;
    logic signed [11:0] i_imm;
    logic signed [11:0] s_imm;
    logic signed [12:0] b_imm;
    logic signed [31:0] u_imm;
    logic signed [20:0] j_imm;

    entry_t            out_q, out_d;
    entry_t            skid_q, skid_d;
    logic              out_valid_q, out_valid_d;
    logic              skid_valid_q, skid_valid_d;
    logic              in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic accept;
    logic handoff;

    assign accept  = in_valid & in_ready_q;
    assign handoff = out_valid_q & out_ready;

    // Decode the incoming instruction into a complete buffer entry.
    // Every recognised opcode already has instr[1:0] == 2'b11, so anything
    // falling to the default arm (including non-32-bit encodings) is illegal.
    always_comb begin
        i_imm = in_instr[31:20];
        s_imm = {in_instr[31:25], in_instr[11:7]};
        b_imm = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
        u_imm = {in_instr[31:12], 12'b0};
        j_imm = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

        dec       = '0;
        dec.instr = in_instr;
        case (in_instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: begin
                dec.fmt = FMT_I;
                dec.imm = XLEN'(i_imm);
            end
            7'b0100011: begin
                dec.fmt = FMT_S;
                dec.imm = XLEN'(s_imm);
            end
            7'b1100011: begin
                dec.fmt = FMT_B;
                dec.imm = XLEN'(b_imm);
            end
            7'b0110111, 7'b0010111: begin
                dec.fmt = FMT_U;
                dec.imm = XLEN'(u_imm);
            end
            7'b1101111: begin
                dec.fmt = FMT_J;
                dec.imm = XLEN'(j_imm);
            end
            7'b0110011: begin
                dec.fmt = FMT_R;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
        dec.target = in_pc + dec.imm;
    end

    // Skid-buffer next state and illegal counter; flush empties both entries
    // but leaves the counter alone, cnt_clr beats a same-cycle increment.
    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        cnt_d        = cnt_q;

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (handoff) begin
                if (skid_valid_q) begin
                    out_d        = skid_q;
                    skid_valid_d = 1'b0;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
            // accept implies the skid register is empty (in_ready_q tracks it)
            if (accept) begin
                if (!out_valid_q || handoff) begin
                    out_d       = dec;
                    out_valid_d = 1'b1;
                end else begin
                    skid_d       = dec;
                    skid_valid_d = 1'b1;
                end
            end
        end

        if (cnt_clr) begin
            cnt_d = '0;
        end else if (accept && !flush && dec.illegal && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        in_ready_d = ~skid_valid_d;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            cnt_q        <= '0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            cnt_q        <= cnt_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_instr   = out_q.instr;
    assign out_imm     = out_q.imm;
    assign out_fmt     = out_q.fmt;
    assign out_target  = out_q.target;
    assign out_illegal = out_q.illegal;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: a 32-bit and a 64-bit instance share stimulus;
// a FIFO-level model (capacity 2) predicts every output each cycle.
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready, flush, cnt_clr;
    logic [31:0] in_instr, in_pc;
    logic [63:0] in_pc64;

    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_instr32, out_imm32, out_target32;
    logic [2:0]  out_fmt32;
    logic [1:0]  cnt32;

    logic        in_ready64, out_valid64, out_illegal64;
    logic [31:0] out_instr64;
    logic [63:0] out_imm64, out_target64;
    logic [2:0]  out_fmt64;
    logic [1:0]  cnt64;

    int tests = 0;
    int fails = 0;

    assign in_pc64 = {32'h0, in_pc};

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32), .CNT_W(2)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid32),
        .out_ready(out_ready), .out_instr(out_instr32), .out_imm(out_imm32),
        .out_fmt(out_fmt32), .out_target(out_target32), .out_illegal(out_illegal32),
        .flush(flush), .cnt_clr(cnt_clr), .illegal_cnt(cnt32)
    );

    imm_decode_stage #(.XLEN(64), .CNT_W(2)) u64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_pc(in_pc64), .out_valid(out_valid64),
        .out_ready(out_ready), .out_instr(out_instr64), .out_imm(out_imm64),
        .out_fmt(out_fmt64), .out_target(out_target64), .out_illegal(out_illegal64),
        .flush(flush), .cnt_clr(cnt_clr), .illegal_cnt(cnt64)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decode: collect the immediate field bits, then sign-extend
    // arithmetically by subtracting 2^bits when the top field bit is set.
    function automatic void ref_decode(input logic [31:0] ins, output logic [63:0] imm,
                                       output logic [2:0] fmt, output logic ill);
        logic [63:0] raw;
        int          bits;
        raw = 64'h0; bits = 1; fmt = 3'd0; ill = 1'b0;
        case (ins[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: begin
                fmt = 3'd1; raw = 64'(ins[31:20]); bits = 12;
            end
            7'b0100011: begin
                fmt = 3'd2; raw = 64'({ins[31:25], ins[11:7]}); bits = 12;
            end
            7'b1100011: begin
                fmt = 3'd3; raw = 64'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}); bits = 13;
            end
            7'b0110111, 7'b0010111: begin
                fmt = 3'd4; raw = 64'({ins[31:12], 12'h000}); bits = 32;
            end
            7'b1101111: begin
                fmt = 3'd5; raw = 64'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}); bits = 21;
            end
            7'b0110011: fmt = 3'd0;
            default:    ill = 1'b1;
        endcase
        imm = raw;
        if (raw[bits-1]) imm = raw - (64'd1 << bits);
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    int          mcnt = 0;
    bit          started = 1'b0;
    logic [31:0] handed[$];

    // Model update: the stage behaves as an in-order FIFO of capacity two.
    always @(posedge clk) begin
        int  n;
        bit  hand, acc;
        logic [63:0] eimm;
        logic [2:0]  efmt;
        logic        eill;
        started = 1'b1;
        if (!rst_n) begin
            mq.delete();
            mcnt = 0;
        end else if (flush) begin
            mq.delete();
            if (cnt_clr) mcnt = 0;
        end else begin
            n    = mq.size();
            hand = (n > 0) && out_ready;
            acc  = in_valid && (n < 2);
            if (hand) begin
                handed.push_back(mq[0].instr);
                void'(mq.pop_front());
            end
            if (acc) mq.push_back('{instr: in_instr, pc: in_pc});
            ref_decode(in_instr, eimm, efmt, eill);
            if (cnt_clr) mcnt = 0;
            else if (acc && eill && mcnt < 3) mcnt++;
        end
    end

    // Per-cycle compare of both instances against the model.
    always @(negedge clk) begin
        logic [63:0] eimm;
        logic [2:0]  efmt;
        logic        eill;
        logic [63:0] et64;
        if (started) begin
            chk("in_ready32", in_ready32, mq.size() < 2);
            chk("in_ready64", in_ready64, mq.size() < 2);
            chk("out_valid32", out_valid32, mq.size() > 0);
            chk("out_valid64", out_valid64, mq.size() > 0);
            chk("cnt32", cnt32, mcnt);
            chk("cnt64", cnt64, mcnt);
            if (mq.size() > 0) begin
                ref_decode(mq[0].instr, eimm, efmt, eill);
                et64 = {32'h0, mq[0].pc} + eimm;
                chk("instr32", out_instr32, mq[0].instr);
                chk("imm32", out_imm32, eimm[31:0]);
                chk("fmt32", out_fmt32, efmt);
                chk("target32", out_target32, et64[31:0]);
                chk("illegal32", out_illegal32, eill);
                chk("instr64", out_instr64, mq[0].instr);
                chk("imm64", out_imm64, eimm);
                chk("fmt64", out_fmt64, efmt);
                chk("target64", out_target64, et64);
                chk("illegal64", out_illegal64, eill);
            end
        end
    end

    // One-cycle offer; caller guarantees in_ready=1 and out_ready=1.
    task automatic send(input logic [31:0] ins, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, out_valid32, 0);
        chk({tag, "_ready"}, in_ready32, 1);
        chk({tag, "_instr"}, out_instr32, 0);
        chk({tag, "_imm"}, out_imm32, 0);
        chk({tag, "_fmt"}, out_fmt32, 0);
        chk({tag, "_target"}, out_target32, 0);
        chk({tag, "_illegal"}, out_illegal32, 0);
        chk({tag, "_cnt"}, cnt32, 0);
        chk({tag, "_imm64"}, out_imm64, 0);
        chk({tag, "_target64"}, out_target64, 0);
    endtask

    localparam logic [31:0] VEC[8] = '{
        32'h002081B3,  // add  (R)
        32'h00112623,  // sw x1,12(x2)
        32'hFE112E23,  // sw, negative offset
        32'h123450B7,  // lui
        32'h80000097,  // auipc, negative upper
        32'h00100010,  // low bits 00 -> illegal
        32'h8000006F,  // jal, most negative offset
        32'h00008067   // jalr
    };

    localparam logic [31:0] INS_A = 32'h00500093;
    localparam logic [31:0] INS_B = 32'h00112623;
    localparam logic [31:0] INS_C = 32'h004000EF;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] mimm;
        logic [2:0]  mfmt;
        logic        mill;

        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        out_ready = 1'b1; flush = 1'b0; cnt_clr = 1'b0;

        ref_decode(32'hFFF00093, mimm, mfmt, mill);
        chk("model_addi_imm", mimm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("model_addi_fmt", mfmt, 3'd1);
        ref_decode(32'hFE000EE3, mimm, mfmt, mill);
        chk("model_beq_imm", mimm, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("model_beq_fmt", mfmt, 3'd3);
        ref_decode(32'h004000EF, mimm, mfmt, mill);
        chk("model_jal_imm", mimm, 64'h4);
        chk("model_jal_fmt", mfmt, 3'd5);
        ref_decode(32'h00000000, mimm, mfmt, mill);
        chk("model_zero_ill", mill, 1'b1);

        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        send(32'hFFF00093, 32'h0);
        chk("addi_valid", out_valid32, 1);
        chk("addi_imm", out_imm32, 32'hFFFFFFFF);
        chk("addi_fmt", out_fmt32, 3'd1);
        chk("addi_target", out_target32, 32'hFFFFFFFF);

        send(32'hFE000EE3, 32'h100);
        chk("beq_imm", out_imm32, 32'hFFFFFFFC);
        chk("beq_fmt", out_fmt32, 3'd3);
        chk("beq_target", out_target32, 32'h000000FC);
        chk("beq_imm64", out_imm64, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("beq_target64", out_target64, 64'hFC);

        send(32'h004000EF, 32'h1000);
        chk("jal_imm", out_imm32, 32'h4);
        chk("jal_fmt", out_fmt32, 3'd5);
        chk("jal_target", out_target32, 32'h1004);

        for (int i = 0; i < 8; i++) send(VEC[i], 32'h4000 + 32'(i * 4));
        @(negedge clk);

        // backpressure: A, B fill the buffer, C stalls until out_ready rises
        handed.delete();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = INS_A; in_pc = 32'h200;
        @(negedge clk);
        chk("bp_a_out", out_instr32, INS_A);
        in_instr = INS_B; in_pc = 32'h204;
        @(negedge clk);
        chk("bp_full_ready", in_ready32, 0);
        in_instr = INS_C; in_pc = 32'h208;
        repeat (2) @(negedge clk);
        chk("bp_stall_ready", in_ready32, 0);
        chk("bp_hold_instr", out_instr32, INS_A);
        chk("bp_hold_target", out_target32, 32'h205);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_drained", out_valid32, 0);
        chk("bp_count", handed.size(), 3);
        if (handed.size() == 3) begin
            chk("bp_order0", handed[0], INS_A);
            chk("bp_order1", handed[1], INS_B);
            chk("bp_order2", handed[2], INS_C);
        end

        // illegal counting with saturation and clear
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        chk("clr0_cnt", cnt32, 0);
        for (int i = 0; i < 5; i++) begin
            send(32'h0, 32'(i * 4));
            chk("ill_flag", out_illegal32, 1);
            chk("ill_imm", out_imm32, 0);
            chk("ill_fmt", out_fmt32, 0);
        end
        chk("ill_sat", cnt32, 2'd3);
        chk("ill_sat64", cnt64, 2'd3);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        chk("ill_clr", cnt32, 0);
        cnt_clr = 1'b1;
        send(32'h0, 32'h0);
        cnt_clr = 1'b0;
        chk("clr_beats_inc", cnt32, 0);
        @(negedge clk);

        // flush with both entries held
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h0; in_pc = 32'h300;
        @(negedge clk);
        in_instr = INS_B; in_pc = 32'h304;
        @(negedge clk);
        chk("fl_full", in_ready32, 0);
        chk("fl_cnt_before", cnt32, 1);
        flush = 1'b1; in_instr = 32'h0;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", out_valid32, 0);
        chk("fl_ready", in_ready32, 1);
        chk("fl_cnt", cnt32, 1);

        // flush with one entry and an acceptable illegal input on offer
        in_valid = 1'b1; in_instr = 32'h0; in_pc = 32'h310;
        @(negedge clk);
        chk("fl1_cnt_inc", cnt32, 2);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("fl1_valid", out_valid32, 0);
        chk("fl1_cnt", cnt32, 2);
        repeat (2) @(negedge clk);
        chk("fl1_stays_empty", out_valid32, 0);

        // reset with both entries held; beats flush
        in_valid = 1'b1; in_instr = INS_A; in_pc = 32'h400;
        @(negedge clk);
        in_instr = INS_C; in_pc = 32'h404;
        @(negedge clk);
        chk("rst_full", in_ready32, 0);
        rst_n = 1'b0; flush = 1'b1; in_instr = 32'h0;
        @(negedge clk);
        chk_all_zero("midrst");
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_valid", out_valid32, 0);
        chk("post_rst_cnt", cnt32, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
